// File: rtl/seg7_pkg.sv
// Shared segment patterns, digit index type and BCD field payload for the HH.MM.SS scan display.
package seg7_pkg;

  localparam logic [7:0] NUMBER_0    = 8'hC0;
  localparam logic [7:0] NUMBER_1    = 8'hF9;
  localparam logic [7:0] NUMBER_2    = 8'hA4;
  localparam logic [7:0] NUMBER_3    = 8'hB0;
  localparam logic [7:0] NUMBER_4    = 8'h99;
  localparam logic [7:0] NUMBER_5    = 8'h92;
  localparam logic [7:0] NUMBER_6    = 8'h82;
  localparam logic [7:0] NUMBER_7    = 8'hF8;
  localparam logic [7:0] NUMBER_8    = 8'h80;
  localparam logic [7:0] NUMBER_9    = 8'h90;
  localparam logic [7:0] SEG_DASH    = 8'hBF;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] DP_LIT_MASK = 8'h7F;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t IDX_SEC_UNITS = 3'd0;
  localparam digit_idx_t IDX_SEC_TENS  = 3'd1;
  localparam digit_idx_t IDX_MIN_UNITS = 3'd2;
  localparam digit_idx_t IDX_MIN_TENS  = 3'd3;
  localparam digit_idx_t IDX_HR_UNITS  = 3'd4;
  localparam digit_idx_t IDX_HR_TENS   = 3'd5;
  localparam digit_idx_t IDX_LAST      = IDX_HR_TENS;

  typedef struct packed {
    logic       oor;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_field_t;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = NUMBER_0;
      4'd1:    s = NUMBER_1;
      4'd2:    s = NUMBER_2;
      4'd3:    s = NUMBER_3;
      4'd4:    s = NUMBER_4;
      4'd5:    s = NUMBER_5;
      4'd6:    s = NUMBER_6;
      4'd7:    s = NUMBER_7;
      4'd8:    s = NUMBER_8;
      4'd9:    s = NUMBER_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational 6-bit binary to two-digit BCD with an out-of-range flag against LIMIT.
module bin2bcd #(
  parameter int unsigned LIMIT = 60
) (
  input  logic [5:0] bin,
  output logic [3:0] tens_c,
  output logic [3:0] units_c,
  output logic       oor_c
);

  always_comb begin
    tens_c  = 4'(bin / 6'd10);
    units_c = 4'(bin % 6'd10);
    oor_c   = (bin >= 6'(LIMIT));
  end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed seven-segment scan driver for HH.MM.SS, active-low segments and enables.
// Build option: define SEG7_LZ_BLANK_EN to blank a leading zero on the hours tens digit.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [7:0] number,
  output logic [5:0] digit_block
);

  localparam int unsigned P_W   = $clog2(SCAN_DIV);
  localparam logic [P_W-1:0] P_MAX = P_W'(SCAN_DIV - 1);

  logic [P_W-1:0] p;
  digit_idx_t     idx;
  logic [5:0]     hours_q, minutes_q, seconds_q;
  bcd_field_t     hr_bcd, min_bcd, sec_bcd;

  logic [3:0] hr_tens_c, hr_units_c, min_tens_c, min_units_c, sec_tens_c, sec_units_c;
  logic       hr_oor_c, min_oor_c, sec_oor_c;

  bin2bcd #(.LIMIT(24)) u_hr (
    .bin(hours_q), .tens_c(hr_tens_c), .units_c(hr_units_c), .oor_c(hr_oor_c)
  );
  bin2bcd #(.LIMIT(60)) u_min (
    .bin(minutes_q), .tens_c(min_tens_c), .units_c(min_units_c), .oor_c(min_oor_c)
  );
  bin2bcd #(.LIMIT(60)) u_sec (
    .bin(seconds_q), .tens_c(sec_tens_c), .units_c(sec_units_c), .oor_c(sec_oor_c)
  );

  // Field capture, then BCD registered one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      hr_bcd    <= '0;
      min_bcd   <= '0;
      sec_bcd   <= '0;
    end else begin
      if (load) begin
        hours_q   <= hours;
        minutes_q <= minutes;
        seconds_q <= seconds;
      end
      hr_bcd  <= '{oor: hr_oor_c,  tens: hr_tens_c,  units: hr_units_c};
      min_bcd <= '{oor: min_oor_c, tens: min_tens_c, units: min_units_c};
      sec_bcd <= '{oor: sec_oor_c, tens: sec_tens_c, units: sec_units_c};
    end
  end

  // Prescaler and digit index; idx steps only on the prescaler wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      idx <= '0;
    end else if (p == P_MAX) begin
      p   <= '0;
      idx <= (idx == IDX_LAST) ? digit_idx_t'(0) : idx + 3'd1;
    end else begin
      p <= p + P_W'(1);
    end
  end

  logic blank_c;
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (p < P_W'(BLANK_CYCLES));
    end
  endgenerate

  bcd_field_t field_c;
  logic       use_tens_c, dp_c, idx_ok_c, lz_c;
  logic [3:0] digit_c;
  logic [7:0] pattern_c;
  logic [5:0] enable_c;

  always_comb begin
    field_c    = '0;
    use_tens_c = 1'b0;
    dp_c       = 1'b0;
    idx_ok_c   = 1'b1;
    lz_c       = 1'b0;
    case (idx)
      IDX_SEC_UNITS: field_c = sec_bcd;
      IDX_SEC_TENS: begin
        field_c    = sec_bcd;
        use_tens_c = 1'b1;
      end
      IDX_MIN_UNITS: begin
        field_c = min_bcd;
        dp_c    = 1'b1;
      end
      IDX_MIN_TENS: begin
        field_c    = min_bcd;
        use_tens_c = 1'b1;
      end
      IDX_HR_UNITS: begin
        field_c = hr_bcd;
        dp_c    = 1'b1;
      end
      IDX_HR_TENS: begin
        field_c    = hr_bcd;
        use_tens_c = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        lz_c       = !hr_bcd.oor && (hr_bcd.tens == 4'd0);
`endif
      end
      default: idx_ok_c = 1'b0;
    endcase

    digit_c = use_tens_c ? field_c.tens : field_c.units;

    // An out-of-range field shows only segment g, without its decimal point
    if (!idx_ok_c || lz_c)   pattern_c = SEG_BLANK;
    else if (field_c.oor)    pattern_c = SEG_DASH;
    else if (dp_c)           pattern_c = seg_of(digit_c) & DP_LIT_MASK;
    else                     pattern_c = seg_of(digit_c);

    enable_c = idx_ok_c ? ~(6'(1) << idx) : 6'b111111;
  end

  // Registered outputs, dark during the blanking window
  always_ff @(posedge clk) begin
    if (rst || blank_c) begin
      number      <= SEG_BLANK;
      digit_block <= 6'b111111;
    end else begin
      number      <= pattern_c;
      digit_block <= enable_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  localparam logic [7:0] N0 = 8'hC0, N1 = 8'hF9, N3 = 8'hB0, N4 = 8'h99, N5 = 8'h92;
  localparam logic [7:0] N7 = 8'hF8, N8 = 8'h80, N9 = 8'h90;
  localparam logic [7:0] DASH = 8'hBF, DARK = 8'hFF;
  localparam logic [7:0] DPM = 8'h7F;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] HT0 = DARK;
`else
  localparam logic [7:0] HT0 = N0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] hours = '0, minutes = '0, seconds = '0;
  logic [7:0] number;
  logic [5:0] digit_block;

  int checks = 0;
  int failures = 0;
  int gcyc = 0;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .hours(hours), .minutes(minutes),
    .seconds(seconds), .number(number), .digit_block(digit_block)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  // State (p, idx) that the outputs at edge k (k >= 1 after the reset edge) reflect
  function automatic int st_p(input int k);
    return (k - 1) % SD;
  endfunction
  function automatic int st_idx(input int k);
    return ((k - 1) / SD) % 6;
  endfunction

  task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    hours = h; minutes = m; seconds = s;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
  endtask

  // One full refresh; check the first lit cycle of every slot
  task automatic check_slots(input string name, input logic [47:0] exp);
    logic [7:0] e;
    logic [5:0] eb;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (st_p(gcyc) == int'(BC)) begin
        e  = exp[st_idx(gcyc)*8 +: 8];
        eb = ~(6'(1) << st_idx(gcyc));
        checks++;
        if (number !== e || digit_block !== eb) begin
          failures++;
          $display("FAIL %s idx%0d: number=%h digit_block=%b, required number=%h digit_block=%b",
                   name, st_idx(gcyc), number, digit_block, e, eb);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] eb;
    rst = 1'b1;
    tick();
    checks++;
    if (number !== DARK || digit_block !== 6'b111111) begin
      failures++;
      $display("FAIL reset: number=%h digit_block=%b, required ff 111111", number, digit_block);
    end
    rst = 1'b0;
    gcyc = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 2 || k == 9 || k == 10) eb = 6'b111111;
      else if (k <= 8)                 eb = 6'b111110;
      else                             eb = 6'b111101;
      checks++;
      if (digit_block !== eb) begin
        failures++;
        $display("FAIL scan_start edge%0d: digit_block=%b, required %b", k, digit_block, eb);
      end
    end
    while (gcyc < 50) tick();
    checks++;
    if (digit_block !== 6'b111111 || number !== DARK) begin
      failures++;
      $display("FAIL scan_period edge50: digit_block=%b number=%h, required 111111 ff",
               digit_block, number);
    end
    tick();
    checks++;
    if (digit_block !== 6'b111110) begin
      failures++;
      $display("FAIL scan_period edge51: digit_block=%b, required 111110", digit_block);
    end
  endtask

  task automatic test_capture();
    do_load(6'd13, 6'd45, 6'd7);
    check_slots("capture_134507", {N1, N3 & DPM, N4, N5 & DPM, N0, N7});
  endtask

  task automatic test_range();
    do_load(6'd24, 6'd60, 6'd59);
    check_slots("range_246059", {DASH, DASH, DASH, DASH, N5, N9});
  endtask

  task automatic test_lz();
    do_load(6'd5, 6'd0, 6'd0);
    check_slots("lz_050000", {HT0, N5 & DPM, N0, N0 & DPM, N0, N0});
  endtask

  task automatic test_load_latency();
    int guard;
    do_load(6'd13, 6'd45, 6'd7);
    guard = 0;
    while (!(st_p(gcyc) == int'(BC) && st_idx(gcyc) == 0) && guard < 60) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 60) begin
      failures++;
      $display("FAIL latency_sync: idx0 slot not reached, got %0d required <60", guard);
    end
    seconds = 6'd8;
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (number !== N7 || digit_block !== 6'b111110) begin
      failures++;
      $display("FAIL latency_N: number=%h digit_block=%b, required %h 111110", number, digit_block, N7);
    end
    tick();
    checks++;
    if (number !== N7 || digit_block !== 6'b111110) begin
      failures++;
      $display("FAIL latency_N1: number=%h digit_block=%b, required %h 111110", number, digit_block, N7);
    end
    tick();
    checks++;
    if (number !== N8 || digit_block !== 6'b111110) begin
      failures++;
      $display("FAIL latency_N2: number=%h digit_block=%b, required %h 111110", number, digit_block, N8);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while ((gcyc % 48) != 29 && guard < 60) begin
      tick();
      guard++;
    end
    checks++;
    if (digit_block !== 6'b110111) begin
      failures++;
      $display("FAIL mid_pre_idx3: digit_block=%b, required 110111", digit_block);
    end
    rst = 1'b1;
    load = 1'b1;
    hours = 6'd21; minutes = 6'd33; seconds = 6'd33;
    tick();
    rst = 1'b0;
    load = 1'b0;
    checks++;
    if (number !== DARK || digit_block !== 6'b111111) begin
      failures++;
      $display("FAIL mid_reset: number=%h digit_block=%b, required ff 111111", number, digit_block);
    end
    gcyc = 0;
    tick();
    tick();
    checks++;
    if (digit_block !== 6'b111111) begin
      failures++;
      $display("FAIL mid_restart_dark: digit_block=%b, required 111111", digit_block);
    end
    check_slots("mid_restart_zero", {HT0, N0 & DPM, N0, N0 & DPM, N0, N0});
  endtask

  initial begin
    test_reset();
    test_capture();
    test_range();
    test_lz();
    test_load_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Six-digit multiplexed seven-segment scan driver that sits directly downstream of the HH:MM:SS timer. It captures binary hours/minutes/seconds on a load strobe, converts each field to two BCD digits, and time-multiplexes them onto a common-anode display. It drives one active-low digit enable at a time, with an inter-digit blanking interval against ghosting. Segment and enable outputs are registered.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with display dark; 0 ≤ BLANK_CYCLES < SCAN_DIV.

Ports:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- load  input  1  capture strobe for hours/minutes/seconds.
- hours  input  6  binary hours; valid range 0..23.
- minutes  input  6  binary minutes; valid range 0..59.
- seconds  input  6  binary seconds; valid range 0..59.
- number  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-low.
- digit_block  output  6  digit enables, active-low, at most one bit low.

## Operation
- Capture:
  - When load=1 at a clock edge, the three fields are latched.
  - The next edge registers the BCD tens/units digits.
  - load held high recaptures every cycle. rst has priority over load.
- Range check:
  - A field outside its range (hours ≥ 24, minutes/seconds ≥ 60) displays "--" on both of its digits (segment g only lit).
  - The other fields are unaffected.
- Scan counters:
  - Prescaler p counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, digit index idx advances 0→1→…→5→0.
- Digit mapping, for idx = 0..5:
  - idx 0: seconds units on digit_block[0].
  - idx 1: seconds tens on digit_block[1].
  - idx 2: minutes units on digit_block[2].
  - idx 3: minutes tens on digit_block[3].
  - idx 4: hours units on digit_block[4].
  - idx 5: hours tens on digit_block[5].
- Decimal points are lit on idx 2 and 4, giving the "HH.MM.SS" format.
- Blanking:
  - While p < BLANK_CYCLES: digit_block=6'b111111 and number=8'hFF.
  - Otherwise digit_block[idx]=0, all other bits 1, and number shows that digit's pattern.
- Segment patterns for 0..9, dash and blank come from the shared package.
- Reset state:
  - p=0, idx=0, latched fields=0, BCD registers=0.
  - digit_block=6'b111111, number=8'hFF.

## Timing
- Outputs are a one-cycle registered image of (p, idx, BCD).
- After rst deasserts at edge E, the display is dark through edge E+BLANK_CYCLES.
- digit_block becomes 6'b111110 at edge E+BLANK_CYCLES+1 and stays low until the slot ends.
- Slot period is exactly SCAN_DIV cycles. Full refresh is 6·SCAN_DIV cycles.
- Load latency:
  - load sampled at edge N → fields latched at N → BCD valid at N+1 → number changes at N+2 if the affected digit is currently lit.
  - There is no wait for a slot boundary.
- If BLANK_CYCLES=0, slots abut with no dark cycle.
- rst mid-slot: the next edge forces the reset state and scanning restarts at idx 0, p 0.
- idx wrap 5→0 coincides with the p wrap; no extra cycle is inserted.

## Configuration
- Macro SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking on the hours tens digit (idx 5).
  - When the hours value is valid and < 10, that slot shows number=8'hFF.
  - digit_block[5] still pulses low, so the slot timing is unchanged.
  - Out-of-range hours still show "-".
- Undefined: hours tens always displays its digit (e.g. "0").

## Structure
- Package seg7_pkg holds:
  - the segment constants NUMBER_0..NUMBER_9, SEG_DASH (8'hBF) and SEG_BLANK (8'hFF);
  - the digit-index typedef (3-bit) and the digit-to-field mapping constants.
- Sub-module bin2bcd: 6-bit binary in; tens and units (4 bits each) plus an out-of-range flag out.
  - Range limit is a parameter.
  - Instantiated three times: limit 24 for hours, 60 for minutes and seconds.
- Scan counters, blanking and output registers live in seg7_scan.

## Test plan
All tests use SCAN_DIV=8 and BLANK_CYCLES=2.
1. Reset then idle → digit_block=6'b111111 for 3 edges, then 6'b111110 for 6 edges, then dark 2 edges, then 6'b111101; period 48 cycles.
2. load with 13:45:07 → per slot, number = NUMBER_7, NUMBER_0, NUMBER_5 with dp, NUMBER_4, NUMBER_3 with dp, NUMBER_1.
3. load with 24:60:59 → hours and minutes digits show SEG_DASH; seconds show 9, 5.
4. load with 05:00:00, both with and without SEG7_LZ_BLANK_EN → the idx 5 slot shows 8'hFF when defined and NUMBER_0 when undefined; idx 4 shows NUMBER_5 with dp in both cases.
5. Pulse load with seconds changing 07→08 while idx 0 is lit → number changes exactly 2 edges after load; digit_block is unaffected.
6. Assert rst during idx 3, p=5, together with load=1 → the next edge gives the reset outputs and fields 0; scanning restarts at idx 0 and the load is ignored.
